// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives all four A/B combinations into an external
// gates block, waits SETTLE cycles per combination, then compares the
// eight-gate result vector against the ideal truth table and accumulates
// mismatch statistics.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  output logic [1:0] ab_out,
  input  logic [7:0] gates_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [7:0] diff_acc
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] ab_nxt;
  logic [2:0] err_nxt;
  logic [3:0] mask_nxt;
  logic [7:0] diff_nxt;
  logic [7:0] diff_now;
  logic [1:0] idx_inc;

  // Ideal gate outputs for combination idx: {NOTB,NOTA,XNOR,NOR,NAND,XOR,OR,AND}.
  function automatic logic [7:0] expected_vec(input logic [1:0] i);
    case (i)
      2'd0:    expected_vec = 8'hF8;
      2'd1:    expected_vec = 8'h4E;
      2'd2:    expected_vec = 8'h8E;
      default: expected_vec = 8'h23;
    endcase
  endfunction

  // Saturating increment; only four combinations can ever mismatch.
  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    sat_inc = (c >= 3'd4) ? 3'd4 : c + 3'd1;
  endfunction

  assign diff_now = gates_in ^ expected_vec(idx);
  assign idx_inc  = idx + 2'd1;

  // Next-state and datapath updates; everything holds unless enabled.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    ab_nxt    = ab_out;
    err_nxt   = err_count;
    mask_nxt  = fail_mask;
    diff_nxt  = diff_acc;
    if (ena) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt = ST_SETTLE;
            idx_nxt   = 2'd0;
            cnt_nxt   = 4'd0;
            ab_nxt    = 2'b00;
            err_nxt   = 3'd0;
            mask_nxt  = 4'h0;
            diff_nxt  = 8'h00;
          end
        end
        ST_SETTLE: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == CNT_LAST) state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (diff_now != 8'h00) begin
            err_nxt  = sat_inc(err_count);
            mask_nxt = fail_mask | (4'b0001 << idx);
            diff_nxt = diff_acc | diff_now;
          end
          if (idx == 2'd3) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx_inc;
            ab_nxt    = {idx_inc[0], idx_inc[1]};
            cnt_nxt   = 4'd0;
            state_nxt = ST_SETTLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      ab_out    <= 2'b00;
      err_count <= 3'd0;
      fail_mask <= 4'h0;
      diff_acc  <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      ab_out    <= ab_nxt;
      err_count <= err_nxt;
      fail_mask <= mask_nxt;
      diff_acc  <= diff_nxt;
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 3'd0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: vector table of corruption patterns,
// randomized sweeps against a truth-table model, and corner-case sequences.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst, ena, start;

  logic [1:0] ab2, ab1, ab15;
  logic [7:0] gates2, gates1, gates15;
  logic busy2, done2, pass2, busy1, done1, pass1, busy15, done15, pass15;
  logic [2:0] err2, err1, err15;
  logic [3:0] mask2, mask1, mask15;
  logic [7:0] diff2, diff1, diff15;

  logic [7:0] corr [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Ideal gates block computed from the logic operations themselves.
  function automatic logic [7:0] ideal(input logic [1:0] ab);
    logic a, b;
    a = ab[0];
    b = ab[1];
    return {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  // Combination i is (A,B) = (i[1], i[0]); ab_out carries A in bit 0.
  function automatic logic [1:0] ab_of(input int i);
    logic [1:0] v;
    v = 2'(i);
    return {v[0], v[1]};
  endfunction

  assign gates2  = ideal(ab2) ^ corr[{ab2[0], ab2[1]}];
  assign gates1  = ideal(ab1);
  assign gates15 = ideal(ab15);

  gate_sweep_checker #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .ab_out(ab2),
    .gates_in(gates2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_mask(mask2), .diff_acc(diff2));

  gate_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .ab_out(ab1),
    .gates_in(gates1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1), .diff_acc(diff1));

  gate_sweep_checker #(.SETTLE(15)) dut15 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .ab_out(ab15),
    .gates_in(gates15), .busy(busy15), .done(done15), .pass(pass15),
    .err_count(err15), .fail_mask(mask15), .diff_acc(diff15));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] c [4];
    logic [2:0] err;
    logic [3:0] mask;
    logic [7:0] diff;
  } vec_t;

  vec_t vecs [6];

  // Full sweep on the SETTLE=2 instance with optional random ena gaps,
  // a scripted ena pause and random start pulses while busy.
  task automatic sweep(input string tag, input int low_pct, input int pause_k,
                       input int pause_len, input bit glitch,
                       input logic [2:0] e_err, input logic [3:0] e_mask,
                       input logic [7:0] e_diff);
    int n, k, lows, pl;
    bit en_now;
    n = 0; k = 0; lows = 0; pl = 0;
    ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy2), 32'd1);
    chk({tag, "_acc_done"}, 32'(done2), 32'd0);
    chk({tag, "_acc_ab"}, 32'(ab2), 32'd0);
    chk({tag, "_acc_err"}, 32'(err2), 32'd0);
    while (done2 !== 1'b1 && n < 400) begin
      if (k == pause_k && pl < pause_len) begin
        en_now = 1'b0;
        pl++;
      end else begin
        en_now = ($urandom_range(99) >= low_pct);
      end
      ena = en_now;
      start = glitch ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
      n++;
      if (en_now) k++; else lows++;
      if (k < 12) begin
        chk({tag, "_ab"}, 32'(ab2), 32'(ab_of(k / 3)));
        chk({tag, "_busy"}, 32'(busy2), 32'd1);
      end
    end
    ena = 1'b1; start = 1'b0;
    chk({tag, "_edges"}, 32'(n), 32'(12 + lows));
    chk({tag, "_done"}, 32'(done2), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy2), 32'd0);
    chk({tag, "_ab_hold"}, 32'(ab2), 32'd3);
    chk({tag, "_err"}, 32'(err2), 32'(e_err));
    chk({tag, "_mask"}, 32'(mask2), 32'(e_mask));
    chk({tag, "_diff"}, 32'(diff2), 32'(e_diff));
    chk({tag, "_pass"}, 32'(pass2), 32'(e_err == 3'd0));
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_corr();
    for (int i = 0; i < 4; i++) corr[i] = 8'h00;
  endtask

  initial begin
    int n, d1, d15;
    logic [2:0] m_err;
    logic [3:0] m_mask;
    logic [7:0] m_diff;

    vecs[0].c = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[0].err = 3'd0; vecs[0].mask = 4'b0000; vecs[0].diff = 8'h00;
    vecs[1].c = '{8'h00, 8'h04, 8'h04, 8'h00}; vecs[1].err = 3'd2; vecs[1].mask = 4'b0110; vecs[1].diff = 8'h04;
    vecs[2].c = '{8'hFF, 8'h00, 8'h00, 8'h00}; vecs[2].err = 3'd1; vecs[2].mask = 4'b0001; vecs[2].diff = 8'hFF;
    vecs[3].c = '{8'h01, 8'h02, 8'h04, 8'h08}; vecs[3].err = 3'd4; vecs[3].mask = 4'b1111; vecs[3].diff = 8'h0F;
    vecs[4].c = '{8'h00, 8'h00, 8'h00, 8'h80}; vecs[4].err = 3'd1; vecs[4].mask = 4'b1000; vecs[4].diff = 8'h80;
    vecs[5].c = '{8'h10, 8'h10, 8'h10, 8'h10}; vecs[5].err = 3'd4; vecs[5].mask = 4'b1111; vecs[5].diff = 8'h10;

    clear_corr();
    do_reset();
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_pass", 32'(pass2), 32'd0);
    chk("rst_ab", 32'(ab2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_mask", 32'(mask2), 32'd0);
    chk("rst_diff", 32'(diff2), 32'd0);

    // Table-driven corruption patterns (includes ideal and XOR stuck-at-0).
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) corr[i] = vecs[v].c[i];
      sweep($sformatf("vec%0d", v), 0, -1, 0, 1'b0, vecs[v].err, vecs[v].mask, vecs[v].diff);
    end

    // ena held low for 5 cycles in idx=1 SETTLE; done 5 edges later.
    clear_corr();
    sweep("ena_pause", 0, 4, 5, 1'b0, 3'd0, 4'h0, 8'h00);

    // Start pulses while busy must not restart the sweep.
    corr[2] = 8'h21;
    sweep("glitch", 0, -1, 0, 1'b1, 3'd1, 4'b0100, 8'h21);

    // Reset mid-sweep (idx=2) with ena low and start high.
    clear_corr();
    corr[0] = 8'hFF;
    ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    chk("mid_ab_idx2", 32'(ab2), 32'(ab_of(2)));
    chk("mid_err", 32'(err2), 32'd1);
    rst = 1'b1; ena = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ena = 1'b1; start = 1'b0;
    chk("mrst_busy", 32'(busy2), 32'd0);
    chk("mrst_done", 32'(done2), 32'd0);
    chk("mrst_ab", 32'(ab2), 32'd0);
    chk("mrst_err", 32'(err2), 32'd0);
    chk("mrst_mask", 32'(mask2), 32'd0);
    chk("mrst_diff", 32'(diff2), 32'd0);
    @(posedge clk); #1;
    chk("mrst_idle", 32'(busy2), 32'd0);
    clear_corr();
    sweep("after_rst", 0, -1, 0, 1'b0, 3'd0, 4'h0, 8'h00);

    // start held high: DONE lasts one cycle then restart clears results.
    corr[3] = 8'h40;
    start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_edges", 32'(n), 32'd12);
    chk("hold_err", 32'(err2), 32'd1);
    chk("hold_mask", 32'(mask2), 32'b1000);
    @(posedge clk); #1;
    chk("hold_restart_done", 32'(done2), 32'd0);
    chk("hold_restart_busy", 32'(busy2), 32'd1);
    chk("hold_restart_err", 32'(err2), 32'd0);
    start = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold_second_edges", 32'(n), 32'd12);

    // Randomized sweeps against the truth-table model.
    for (int r = 0; r < 20; r++) begin
      m_err = 3'd0; m_mask = 4'h0; m_diff = 8'h00;
      for (int i = 0; i < 4; i++) begin
        corr[i] = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        if (corr[i] != 8'h00) begin
          m_err++;
          m_mask[i] = 1'b1;
          m_diff |= corr[i];
        end
      end
      sweep($sformatf("rnd%0d", r), 30, -1, 0, 1'b1, m_err, m_mask, m_diff);
    end

    // SETTLE=1 and SETTLE=15 timing.
    clear_corr();
    do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d1 = -1; d15 = -1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (d1 < 0 && done1 === 1'b1) d1 = e;
      if (d15 < 0 && done15 === 1'b1) d15 = e;
    end
    chk("s1_done_edge", 32'(d1), 32'd8);
    chk("s15_done_edge", 32'(d15), 32'd64);
    chk("s1_pass", 32'(pass1), 32'd1);
    chk("s15_pass", 32'(pass15), 32'd1);
    chk("s1_err", 32'({err1, mask1, diff1}), 32'd0);
    chk("s15_err", 32'({err15, mask15, diff15}), 32'd0);
    chk("s1_ab", 32'({busy1, ab1}), 32'd3);
    chk("s15_ab", 32'({busy15, ab15}), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
